// File: rtl/zx81_kbd_pkg.sv
// zx81_kbd_pkg: shared constants and types for the ZX81 keyboard matrix.
// Holds matrix row/column indices, PS/2 set-2 scancodes, the compound-key
// index enum and the decode result struct produced by zx81_scancode_lut.
package zx81_kbd_pkg;

    localparam int NUM_ROWS = 8;
    localparam int NUM_COLS = 5;

    // Matrix rows (row n is selected by Z80 address bit A8+n being 0)
    localparam logic [2:0] ROW_SHIFT_V  = 3'd0;
    localparam logic [2:0] ROW_A_G      = 3'd1;
    localparam logic [2:0] ROW_Q_T      = 3'd2;
    localparam logic [2:0] ROW_1_5      = 3'd3;
    localparam logic [2:0] ROW_0_6      = 3'd4;
    localparam logic [2:0] ROW_P_Y      = 3'd5;
    localparam logic [2:0] ROW_ENTER_H  = 3'd6;
    localparam logic [2:0] ROW_SPACE_B  = 3'd7;

    // Matrix columns (data bit positions)
    localparam logic [2:0] COL_0 = 3'd0;
    localparam logic [2:0] COL_1 = 3'd1;
    localparam logic [2:0] COL_2 = 3'd2;
    localparam logic [2:0] COL_3 = 3'd3;
    localparam logic [2:0] COL_4 = 3'd4;

    // PS/2 set-2 scancodes
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_Z      = 8'h1A;
    localparam logic [7:0] SC_X      = 8'h22;
    localparam logic [7:0] SC_C      = 8'h21;
    localparam logic [7:0] SC_V      = 8'h2A;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_S      = 8'h1B;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_F      = 8'h2B;
    localparam logic [7:0] SC_G      = 8'h34;
    localparam logic [7:0] SC_Q      = 8'h15;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_E      = 8'h24;
    localparam logic [7:0] SC_R      = 8'h2D;
    localparam logic [7:0] SC_T      = 8'h2C;
    localparam logic [7:0] SC_1      = 8'h16;
    localparam logic [7:0] SC_2      = 8'h1E;
    localparam logic [7:0] SC_3      = 8'h26;
    localparam logic [7:0] SC_4      = 8'h25;
    localparam logic [7:0] SC_5      = 8'h2E;
    localparam logic [7:0] SC_0      = 8'h45;
    localparam logic [7:0] SC_9      = 8'h46;
    localparam logic [7:0] SC_8      = 8'h3E;
    localparam logic [7:0] SC_7      = 8'h3D;
    localparam logic [7:0] SC_6      = 8'h36;
    localparam logic [7:0] SC_P      = 8'h4D;
    localparam logic [7:0] SC_O      = 8'h44;
    localparam logic [7:0] SC_I      = 8'h43;
    localparam logic [7:0] SC_U      = 8'h3C;
    localparam logic [7:0] SC_Y      = 8'h35;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_L      = 8'h4B;
    localparam logic [7:0] SC_K      = 8'h42;
    localparam logic [7:0] SC_J      = 8'h3B;
    localparam logic [7:0] SC_H      = 8'h33;
    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_PERIOD = 8'h49;
    localparam logic [7:0] SC_M      = 8'h3A;
    localparam logic [7:0] SC_N      = 8'h31;
    localparam logic [7:0] SC_B      = 8'h32;
    localparam logic [7:0] SC_BKSP   = 8'h66;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_F12    = 8'h07;
    localparam logic [7:0] SC_BAT    = 8'hAA;

    // Compound keys: each one presses SHIFT plus a digit key
    typedef enum logic [2:0] {
        CIDX_BKSP  = 3'd0,
        CIDX_LEFT  = 3'd1,
        CIDX_DOWN  = 3'd2,
        CIDX_UP    = 3'd3,
        CIDX_RIGHT = 3'd4
    } cidx_e;

    // Right shift is carried through the compound path as an extra source
    // that only drives SHIFT, keeping it independent of left shift.
    localparam logic [2:0] CIDX_SHIFT_R = 3'd5;

    typedef struct packed {
        logic       valid;
        logic       is_compound;
        logic [2:0] row;
        logic [2:0] col;
        logic [2:0] cidx;
    } decode_t;

    function automatic decode_t direct_key(input logic [2:0] row, input logic [2:0] col);
        decode_t d;
        d             = '0;
        d.valid       = 1'b1;
        d.row         = row;
        d.col         = col;
        return d;
    endfunction

    function automatic decode_t compound_key(input logic [2:0] cidx);
        decode_t d;
        d             = '0;
        d.valid       = 1'b1;
        d.is_compound = 1'b1;
        d.cidx        = cidx;
        return d;
    endfunction

endpackage

// File: rtl/zx81_scancode_lut.sv
// zx81_scancode_lut: combinational PS/2 {ext, code} to ZX81 matrix decode.
// Unmapped codes return valid = 0 and are ignored by the parent.
module zx81_scancode_lut
    import zx81_kbd_pkg::*;
(
    input  logic       ext,
    input  logic [7:0] code,
    output decode_t    dec
);

    // Look up the scancode; extended and plain codes live in separate tables
    always_comb begin
        dec = '0;
        if (!ext) begin
            case (code)
                SC_LSHIFT: dec = direct_key(ROW_SHIFT_V, COL_0);
                SC_RSHIFT: dec = compound_key(CIDX_SHIFT_R);
                SC_Z:      dec = direct_key(ROW_SHIFT_V, COL_1);
                SC_X:      dec = direct_key(ROW_SHIFT_V, COL_2);
                SC_C:      dec = direct_key(ROW_SHIFT_V, COL_3);
                SC_V:      dec = direct_key(ROW_SHIFT_V, COL_4);
                SC_A:      dec = direct_key(ROW_A_G, COL_0);
                SC_S:      dec = direct_key(ROW_A_G, COL_1);
                SC_D:      dec = direct_key(ROW_A_G, COL_2);
                SC_F:      dec = direct_key(ROW_A_G, COL_3);
                SC_G:      dec = direct_key(ROW_A_G, COL_4);
                SC_Q:      dec = direct_key(ROW_Q_T, COL_0);
                SC_W:      dec = direct_key(ROW_Q_T, COL_1);
                SC_E:      dec = direct_key(ROW_Q_T, COL_2);
                SC_R:      dec = direct_key(ROW_Q_T, COL_3);
                SC_T:      dec = direct_key(ROW_Q_T, COL_4);
                SC_1:      dec = direct_key(ROW_1_5, COL_0);
                SC_2:      dec = direct_key(ROW_1_5, COL_1);
                SC_3:      dec = direct_key(ROW_1_5, COL_2);
                SC_4:      dec = direct_key(ROW_1_5, COL_3);
                SC_5:      dec = direct_key(ROW_1_5, COL_4);
                SC_0:      dec = direct_key(ROW_0_6, COL_0);
                SC_9:      dec = direct_key(ROW_0_6, COL_1);
                SC_8:      dec = direct_key(ROW_0_6, COL_2);
                SC_7:      dec = direct_key(ROW_0_6, COL_3);
                SC_6:      dec = direct_key(ROW_0_6, COL_4);
                SC_P:      dec = direct_key(ROW_P_Y, COL_0);
                SC_O:      dec = direct_key(ROW_P_Y, COL_1);
                SC_I:      dec = direct_key(ROW_P_Y, COL_2);
                SC_U:      dec = direct_key(ROW_P_Y, COL_3);
                SC_Y:      dec = direct_key(ROW_P_Y, COL_4);
                SC_ENTER:  dec = direct_key(ROW_ENTER_H, COL_0);
                SC_L:      dec = direct_key(ROW_ENTER_H, COL_1);
                SC_K:      dec = direct_key(ROW_ENTER_H, COL_2);
                SC_J:      dec = direct_key(ROW_ENTER_H, COL_3);
                SC_H:      dec = direct_key(ROW_ENTER_H, COL_4);
                SC_SPACE:  dec = direct_key(ROW_SPACE_B, COL_0);
                SC_PERIOD: dec = direct_key(ROW_SPACE_B, COL_1);
                SC_M:      dec = direct_key(ROW_SPACE_B, COL_2);
                SC_N:      dec = direct_key(ROW_SPACE_B, COL_3);
                SC_B:      dec = direct_key(ROW_SPACE_B, COL_4);
                SC_BKSP:   dec = compound_key(CIDX_BKSP);
                default:   dec = '0;
            endcase
        end else begin
            case (code)
                SC_ENTER:  dec = direct_key(ROW_ENTER_H, COL_0);
                SC_LEFT:   dec = compound_key(CIDX_LEFT);
                SC_DOWN:   dec = compound_key(CIDX_DOWN);
                SC_UP:     dec = compound_key(CIDX_UP);
                SC_RIGHT:  dec = compound_key(CIDX_RIGHT);
                default:   dec = '0;
            endcase
        end
    end

endmodule

// File: rtl/zx81_keymatrix.sv
// zx81_keymatrix: PS/2 key events to ZX81 8x5 keyboard matrix, clk_sys domain.
// Pipeline: S0 toggle detect -> S1 registered decode -> S2 matrix update.
// Optional F12 hold-to-reset request enabled by defining ZX81_KBD_RSTKEY_EN.
module zx81_keymatrix
    import zx81_kbd_pkg::*;
#(
    parameter bit          CLEAR_ON_BAT    = 1'b1,
    parameter int unsigned RST_HOLD_CYCLES = 1250000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [7:0]  row_sel,
    output logic [4:0]  kbd_col,
    output logic        key_event,
    output logic        reset_req
);

    // The hold counter is 21 bits wide, so larger limits could never be reached
    if (RST_HOLD_CYCLES > 32'd2097151) begin : g_hold_range_check
        $error("RST_HOLD_CYCLES does not fit the 21-bit hold counter");
    end

    logic                            init_d, init_q;
    logic                            prev_toggle_d, prev_toggle_q;
    logic                            s0_valid_d, s0_valid_q;
    logic [9:0]                      s0_key_d, s0_key_q;
    decode_t                         lut_dec;
    decode_t                         s1_dec_d, s1_dec_q;
    logic                            s1_press_d, s1_press_q;
    logic                            s1_bat_d, s1_bat_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] phys_d, phys_q;
    logic [4:0]                      compound_d, compound_q;
    logic                            shift_r_d, shift_r_q;
    logic                            key_event_d, key_event_q;
    logic [NUM_ROWS-1:0][NUM_COLS-1:0] eff_matrix;

    // S0: detect a toggle on ps2_key[10]; the first cycle after reset only primes prev_toggle
    always_comb begin
        init_d        = 1'b0;
        prev_toggle_d = ps2_key[10];
        s0_valid_d    = !init_q && (ps2_key[10] != prev_toggle_q);
        s0_key_d      = ps2_key[9:0];
    end

    zx81_scancode_lut u_lut (
        .ext  (s0_key_q[8]),
        .code (s0_key_q[7:0]),
        .dec  (lut_dec)
    );

    // S1: register the decode result, qualified by the S0 event flag
    always_comb begin
        s1_dec_d       = lut_dec;
        s1_dec_d.valid = lut_dec.valid && s0_valid_q;
        s1_press_d     = s0_key_q[9];
        s1_bat_d       = CLEAR_ON_BAT && s0_valid_q && s0_key_q[9] &&
                         !s0_key_q[8] && (s0_key_q[7:0] == SC_BAT);
    end

    // S2: apply the decoded event to the source bits; BAT wipes every source
    always_comb begin
        phys_d      = phys_q;
        compound_d  = compound_q;
        shift_r_d   = shift_r_q;
        key_event_d = s1_dec_q.valid || s1_bat_q;
        if (s1_bat_q) begin
            phys_d     = '0;
            compound_d = '0;
            shift_r_d  = 1'b0;
        end else if (s1_dec_q.valid) begin
            if (s1_dec_q.is_compound) begin
                if (s1_dec_q.cidx == CIDX_SHIFT_R) begin
                    shift_r_d = s1_press_q;
                end else begin
                    compound_d[s1_dec_q.cidx] = s1_press_q;
                end
            end else begin
                phys_d[s1_dec_q.row][s1_dec_q.col] = s1_press_q;
            end
        end
    end

    // Pipeline and matrix state registers; reset discards any in-flight event
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            init_q        <= 1'b1;
            prev_toggle_q <= 1'b0;
            s0_valid_q    <= 1'b0;
            s0_key_q      <= '0;
            s1_dec_q      <= '0;
            s1_press_q    <= 1'b0;
            s1_bat_q      <= 1'b0;
            phys_q        <= '0;
            compound_q    <= '0;
            shift_r_q     <= 1'b0;
            key_event_q   <= 1'b0;
        end else begin
            init_q        <= init_d;
            prev_toggle_q <= prev_toggle_d;
            s0_valid_q    <= s0_valid_d;
            s0_key_q      <= s0_key_d;
            s1_dec_q      <= s1_dec_d;
            s1_press_q    <= s1_press_d;
            s1_bat_q      <= s1_bat_d;
            phys_q        <= phys_d;
            compound_q    <= compound_d;
            shift_r_q     <= shift_r_d;
            key_event_q   <= key_event_d;
        end
    end

    assign key_event = key_event_q;

    // Effective matrix: physical keys OR'd with every compound/shift source
    always_comb begin
        eff_matrix = phys_q;
        if (shift_r_q || (|compound_q)) begin
            eff_matrix[ROW_SHIFT_V][COL_0] = 1'b1;
        end
        if (compound_q[CIDX_BKSP]) begin
            eff_matrix[ROW_0_6][COL_0] = 1'b1;
        end
        if (compound_q[CIDX_LEFT]) begin
            eff_matrix[ROW_1_5][COL_4] = 1'b1;
        end
        if (compound_q[CIDX_DOWN]) begin
            eff_matrix[ROW_0_6][COL_4] = 1'b1;
        end
        if (compound_q[CIDX_UP]) begin
            eff_matrix[ROW_0_6][COL_3] = 1'b1;
        end
        if (compound_q[CIDX_RIGHT]) begin
            eff_matrix[ROW_0_6][COL_2] = 1'b1;
        end
    end

    // Keyboard port read: active-low AND of every selected row
    always_comb begin
        kbd_col = 5'h1F;
        for (int r = 0; r < NUM_ROWS; r++) begin
            if (!row_sel[r]) begin
                kbd_col = kbd_col & ~eff_matrix[r];
            end
        end
    end

`ifdef ZX81_KBD_RSTKEY_EN
    localparam logic [20:0] HOLD_LIMIT = 21'(RST_HOLD_CYCLES);

    logic        s1_f12_d, s1_f12_q;
    logic        f12_held_d, f12_held_q;
    logic [20:0] hold_cnt_d, hold_cnt_q;

    // Track F12 held state and count how long it has been held, saturating at the limit
    always_comb begin
        s1_f12_d   = s0_valid_q && !s0_key_q[8] && (s0_key_q[7:0] == SC_F12);
        f12_held_d = f12_held_q;
        if (s1_f12_q) begin
            f12_held_d = s1_press_q;
        end
        hold_cnt_d = '0;
        if (f12_held_q) begin
            hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q : hold_cnt_q + 21'd1;
        end
    end

    // F12 hold tracking registers
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            s1_f12_q   <= 1'b0;
            f12_held_q <= 1'b0;
            hold_cnt_q <= '0;
        end else begin
            s1_f12_q   <= s1_f12_d;
            f12_held_q <= f12_held_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign reset_req = f12_held_q && (hold_cnt_q == HOLD_LIMIT);
`else
    assign reset_req = 1'b0;
`endif

endmodule
